// File: rtl/circuit_diff.sv
// ---------------------------------------------------------------------------
// circuit_diff
//   Decoder/checker for the running-sum accumulator y(n) = y(n-1) + |x(n)|.
//   Each strobed sample y is differenced against the previous accepted
//   sample to recover |x(n)|. Results are tagged with a sample index and
//   queued in a 2-entry ready/valid buffer.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   en         sample strobe, one sample per cycle
//   y          accumulator sample (YW bits, wraps modulo 2^YW)
//   clr        synchronous clear of sticky flags, index counter and prev
//   x_abs      recovered |x| at buffer head (XW bits)
//   x_n        sample index at buffer head (NW bits)
//   x_valid    buffer head holds data
//   x_ready    consumer accepts head when x_valid & x_ready
//   err_range  sticky: a difference exceeded 2^(XW-1), output was saturated
//   err_ovf    sticky: a sample arrived with the buffer full and was dropped
// ---------------------------------------------------------------------------
module circuit_diff #(
   parameter int YW = 32,
   parameter int XW = 12,
   parameter int NW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic [YW-1:0] y,
   input  logic          clr,
   output logic [XW-1:0] x_abs,
   output logic [NW-1:0] x_n,
   output logic          x_valid,
   input  logic          x_ready,
   output logic          err_range,
   output logic          err_ovf
);

   // Largest legal |x| (2^(XW-1)); also the saturation value.
   localparam logic [YW-1:0] LIMIT = {{(YW-1){1'b0}}, 1'b1} << (XW-1);
   localparam logic [XW-1:0] SAT   = LIMIT[XW-1:0];

   typedef enum logic [1:0] {EMPTY, ONE, TWO} occ_t;

   occ_t          state_q, state_d;
   logic [YW-1:0] prev_q, prev_d;
   logic [NW-1:0] cnt_q, cnt_d;
   logic [XW-1:0] head_abs_q, head_abs_d, tail_abs_q, tail_abs_d;
   logic [NW-1:0] head_n_q, head_n_d, tail_n_q, tail_n_d;
   logic          err_range_q, err_range_d;
   logic          err_ovf_q, err_ovf_d;

   logic          pop, push, full, range_hit;
   logic [YW-1:0] prev_base, diff;
   logic [NW-1:0] cnt_base;
   logic [XW-1:0] new_abs;

   // clr takes effect before the sample of the same cycle is decoded, so
   // that sample is differenced against 0 and tagged with index 0.
   always_comb begin
      prev_base = clr ? '0 : prev_q;
      cnt_base  = clr ? '0 : cnt_q;
      // Modular subtraction decodes accumulator wrap-around for free.
      diff      = y - prev_base;
      range_hit = diff > LIMIT;
      new_abs   = range_hit ? SAT : diff[XW-1:0];
      pop       = (state_q != EMPTY) && x_ready;
      full      = (state_q == TWO);
      // A pop in the same cycle frees a slot, so full + pop still accepts.
      push      = en && (!full || pop);
   end

   always_comb begin
      state_d     = state_q;
      prev_d      = prev_base;
      cnt_d       = cnt_base;
      head_abs_d  = head_abs_q;
      head_n_d    = head_n_q;
      tail_abs_d  = tail_abs_q;
      tail_n_d    = tail_n_q;
      err_range_d = clr ? 1'b0 : err_range_q;
      err_ovf_d   = clr ? 1'b0 : err_ovf_q;

      if (push) begin
         prev_d = y;
         cnt_d  = cnt_base + NW'(1);
         if (range_hit) begin
            err_range_d = 1'b1;
         end
      end
      if (en && !push) begin
         err_ovf_d = 1'b1;
      end

      // Head register is the output; when the buffer drains it simply keeps
      // the last value shown, which gives the hold-when-empty behaviour.
      case (state_q)
         EMPTY: begin
            if (push) begin
               head_abs_d = new_abs;
               head_n_d   = cnt_base;
               state_d    = ONE;
            end
         end
         ONE: begin
            if (push && pop) begin
               head_abs_d = new_abs;
               head_n_d   = cnt_base;
            end else if (push) begin
               tail_abs_d = new_abs;
               tail_n_d   = cnt_base;
               state_d    = TWO;
            end else if (pop) begin
               state_d    = EMPTY;
            end
         end
         TWO: begin
            if (pop) begin
               head_abs_d = tail_abs_q;
               head_n_d   = tail_n_q;
               if (push) begin
                  tail_abs_d = new_abs;
                  tail_n_d   = cnt_base;
               end else begin
                  state_d    = ONE;
               end
            end
         end
         default: begin
            state_d = EMPTY;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= EMPTY;
         prev_q      <= '0;
         cnt_q       <= '0;
         head_abs_q  <= '0;
         head_n_q    <= '0;
         tail_abs_q  <= '0;
         tail_n_q    <= '0;
         err_range_q <= 1'b0;
         err_ovf_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         prev_q      <= prev_d;
         cnt_q       <= cnt_d;
         head_abs_q  <= head_abs_d;
         head_n_q    <= head_n_d;
         tail_abs_q  <= tail_abs_d;
         tail_n_q    <= tail_n_d;
         err_range_q <= err_range_d;
         err_ovf_q   <= err_ovf_d;
      end
   end

   assign x_abs     = head_abs_q;
   assign x_n       = head_n_q;
   assign x_valid   = (state_q != EMPTY);
   assign err_range = err_range_q;
   assign err_ovf   = err_ovf_q;

endmodule

// File: tb/tb_circuit_diff.sv
// ---------------------------------------------------------------------------
// tb_circuit_diff
//   Self-checking bench for circuit_diff. Directed scenarios compare against
//   hand-derived constants; a randomized run compares against a queue-based
//   behavioural model of the decoder and its output buffer.
// ---------------------------------------------------------------------------
module tb_circuit_diff;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [31:0] y;
   logic        clr;
   logic [11:0] x_abs;
   logic [15:0] x_n;
   logic        x_valid;
   logic        x_ready;
   logic        err_range;
   logic        err_ovf;

   always #5 clk = ~clk;

   circuit_diff dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .y         (y),
      .clr       (clr),
      .x_abs     (x_abs),
      .x_n       (x_n),
      .x_valid   (x_valid),
      .x_ready   (x_ready),
      .err_range (err_range),
      .err_ovf   (err_ovf)
   );

   typedef struct packed {
      logic [11:0] a;
      logic [15:0] n;
   } ent_t;

   // Behavioural model: list of pending results plus decoder state.
   ent_t        mq[$];
   ent_t        m_last;
   logic [31:0] m_prev;
   logic [15:0] m_cnt;
   logic        m_range;
   logic        m_ovf;

   int vectors     = 0;
   int miscompares = 0;

   task automatic model_reset();
      mq.delete();
      m_last  = '0;
      m_prev  = '0;
      m_cnt   = '0;
      m_range = 1'b0;
      m_ovf   = 1'b0;
   endtask

   function automatic ent_t exp_head();
      if (mq.size() != 0) return mq[0];
      return m_last;
   endfunction

   // Drive one clock cycle of stimulus and advance the model by one sample
   // period; returns 1 ns after the rising edge.
   task automatic cycle(input logic i_en, input logic [31:0] i_y,
                        input logic i_clr, input logic i_rdy);
      logic        pop, full;
      logic [31:0] base_prev, d;
      logic [15:0] base_cnt;
      ent_t        e;
      @(negedge clk);
      en = i_en; y = i_y; clr = i_clr; x_ready = i_rdy;
      full      = (mq.size() == 2);
      pop       = (mq.size() != 0) && i_rdy;
      base_prev = i_clr ? 32'd0 : m_prev;
      base_cnt  = i_clr ? 16'd0 : m_cnt;
      if (i_clr) begin
         m_range = 1'b0; m_ovf = 1'b0; m_prev = '0; m_cnt = '0;
      end
      if (pop) begin
         m_last = mq.pop_front();
         $display("txn: consumed x_abs=%0d x_n=%0d at %0t", m_last.a, m_last.n, $time);
      end
      if (i_en) begin
         if (!full || pop) begin
            d = i_y - base_prev;
            if (d > 32'd2048) begin
               e.a = 12'd2048;
               m_range = 1'b1;
            end else begin
               e.a = d[11:0];
            end
            e.n = base_cnt;
            mq.push_back(e);
            m_prev = i_y;
            m_cnt  = base_cnt + 16'd1;
         end else begin
            m_ovf = 1'b1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      en = 1'b0; y = '0; clr = 1'b0; x_ready = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      en = 1'b0; y = '0; clr = 1'b0; x_ready = 1'b0;
      rst = 1'b0;
      #1;
      vectors++;
      if ({x_valid, err_range, err_ovf} !== 3'b000) begin
         miscompares++;
         $display("FAIL reset_flags: got valid/range/ovf=%b expected 000", {x_valid, err_range, err_ovf});
      end
      vectors++;
      if ({x_abs, x_n} !== 28'd0) begin
         miscompares++;
         $display("FAIL reset_head: got x_abs=%0d x_n=%0d expected 0/0", x_abs, x_n);
      end
      @(negedge clk);
      rst = 1'b1;
      model_reset();
   endtask

   task automatic test_basic();
      int ys[4]    = '{100, 300, 300, 2348};
      int exp_a[4] = '{100, 200, 0, 2048};
      do_reset();
      for (int i = 0; i < 4; i++) begin
         cycle(1'b0, 32'd0, 1'b0, 1'b1);
         vectors++;
         if (x_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_idle_valid[%0d]: got %b expected 0", i, x_valid);
         end
         cycle(1'b1, ys[i], 1'b0, 1'b1);
         vectors++;
         if (x_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_valid[%0d]: got %b expected 1", i, x_valid);
         end
         vectors++;
         if (x_abs !== exp_a[i][11:0] || x_n !== i[15:0]) begin
            miscompares++;
            $display("FAIL basic_out[%0d]: got (%0d,%0d) expected (%0d,%0d)", i, x_abs, x_n, exp_a[i], i);
         end
      end
      vectors++;
      if (err_range !== 1'b0) begin
         miscompares++;
         $display("FAIL basic_range: got %b expected 0", err_range);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      // Jump straight to just below the wrap point; that step itself is out
      // of range and saturates, the wrap step after it must decode exactly.
      cycle(1'b1, 32'hFFFF_FF00, 1'b0, 1'b1);
      vectors++;
      if (x_abs !== 12'd2048 || err_range !== 1'b1) begin
         miscompares++;
         $display("FAIL wrap_jump: got x_abs=%0d range=%b expected 2048/1", x_abs, err_range);
      end
      cycle(1'b1, 32'h0000_0100, 1'b0, 1'b1);
      vectors++;
      if (x_abs !== 12'h200 || x_n !== 16'd1) begin
         miscompares++;
         $display("FAIL wrap_decode: got (%0h,%0d) expected (200,1)", x_abs, x_n);
      end
   endtask

   task automatic test_range();
      do_reset();
      cycle(1'b1, 32'd3000, 1'b0, 1'b1);
      vectors++;
      if (x_abs !== 12'd2048 || err_range !== 1'b1) begin
         miscompares++;
         $display("FAIL range_sat: got x_abs=%0d range=%b expected 2048/1", x_abs, err_range);
      end
      for (int i = 0; i < 2; i++) begin
         cycle(1'b0, 32'd0, 1'b0, 1'b1);
         vectors++;
         if (err_range !== 1'b1) begin
            miscompares++;
            $display("FAIL range_sticky[%0d]: got %b expected 1", i, err_range);
         end
      end
      cycle(1'b0, 32'd0, 1'b1, 1'b1);
      vectors++;
      if (err_range !== 1'b0) begin
         miscompares++;
         $display("FAIL range_clr: got %b expected 0", err_range);
      end
      // Just over the limit after clr (prev back to 0).
      cycle(1'b1, 32'd2049, 1'b0, 1'b1);
      vectors++;
      if (x_abs !== 12'd2048 || x_n !== 16'd0 || err_range !== 1'b1) begin
         miscompares++;
         $display("FAIL range_2049: got (%0d,%0d) range=%b expected (2048,0) 1", x_abs, x_n, err_range);
      end
      // clr together with a sample: differenced against 0, index 0.
      cycle(1'b1, 32'd700, 1'b1, 1'b1);
      vectors++;
      if (x_abs !== 12'd700 || x_n !== 16'd0 || err_range !== 1'b0) begin
         miscompares++;
         $display("FAIL clr_en: got (%0d,%0d) range=%b expected (700,0) 0", x_abs, x_n, err_range);
      end
      cycle(1'b1, 32'd800, 1'b0, 1'b1);
      vectors++;
      if (x_abs !== 12'd100 || x_n !== 16'd1) begin
         miscompares++;
         $display("FAIL clr_next: got (%0d,%0d) expected (100,1)", x_abs, x_n);
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      cycle(1'b1, 32'd10, 1'b0, 1'b0);
      cycle(1'b1, 32'd20, 1'b0, 1'b0);
      cycle(1'b1, 32'd30, 1'b0, 1'b0);
      vectors++;
      if (err_ovf !== 1'b1 || x_valid !== 1'b1 || x_abs !== 12'd10 || x_n !== 16'd0) begin
         miscompares++;
         $display("FAIL bp_full: got ovf=%b valid=%b (%0d,%0d) expected 1 1 (10,0)", err_ovf, x_valid, x_abs, x_n);
      end
      cycle(1'b0, 32'd0, 1'b0, 1'b1);
      vectors++;
      if (x_valid !== 1'b1 || x_abs !== 12'd10 || x_n !== 16'd1) begin
         miscompares++;
         $display("FAIL bp_second: got valid=%b (%0d,%0d) expected 1 (10,1)", x_valid, x_abs, x_n);
      end
      cycle(1'b0, 32'd0, 1'b0, 1'b1);
      vectors++;
      if (x_valid !== 1'b0 || x_abs !== 12'd10 || x_n !== 16'd1) begin
         miscompares++;
         $display("FAIL bp_empty_hold: got valid=%b (%0d,%0d) expected 0 (10,1)", x_valid, x_abs, x_n);
      end
      cycle(1'b1, 32'd50, 1'b0, 1'b1);
      vectors++;
      if (x_abs !== 12'd30 || x_n !== 16'd2 || err_ovf !== 1'b1) begin
         miscompares++;
         $display("FAIL bp_resume: got (%0d,%0d) ovf=%b expected (30,2) 1", x_abs, x_n, err_ovf);
      end
   endtask

   task automatic test_full_pop();
      do_reset();
      cycle(1'b1, 32'd10, 1'b0, 1'b0);
      cycle(1'b1, 32'd20, 1'b0, 1'b0);
      cycle(1'b1, 32'd40, 1'b0, 1'b1);
      vectors++;
      if (err_ovf !== 1'b0 || x_abs !== 12'd10 || x_n !== 16'd1) begin
         miscompares++;
         $display("FAIL fullpop_accept: got ovf=%b (%0d,%0d) expected 0 (10,1)", err_ovf, x_abs, x_n);
      end
      cycle(1'b0, 32'd0, 1'b0, 1'b1);
      vectors++;
      if (x_valid !== 1'b1 || x_abs !== 12'd20 || x_n !== 16'd2) begin
         miscompares++;
         $display("FAIL fullpop_order: got valid=%b (%0d,%0d) expected 1 (20,2)", x_valid, x_abs, x_n);
      end
      cycle(1'b0, 32'd0, 1'b0, 1'b1);
      vectors++;
      if (x_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL fullpop_drain: got valid=%b expected 0", x_valid);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      cycle(1'b1, 32'd3000, 1'b0, 1'b0);
      cycle(1'b1, 32'd3010, 1'b0, 1'b0);
      cycle(1'b1, 32'd3020, 1'b0, 1'b0);
      vectors++;
      if ({x_valid, err_range, err_ovf} !== 3'b111) begin
         miscompares++;
         $display("FAIL areset_pre: got valid/range/ovf=%b expected 111", {x_valid, err_range, err_ovf});
      end
      @(negedge clk);
      en = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      vectors++;
      if ({x_valid, err_range, err_ovf} !== 3'b000 || x_abs !== 12'd0 || x_n !== 16'd0) begin
         miscompares++;
         $display("FAIL areset_now: got valid/range/ovf=%b (%0d,%0d) expected 000 (0,0)",
                  {x_valid, err_range, err_ovf}, x_abs, x_n);
      end
      #1;
      rst = 1'b1;
      model_reset();
      cycle(1'b1, 32'd500, 1'b0, 1'b1);
      vectors++;
      if (x_valid !== 1'b1 || x_abs !== 12'd500 || x_n !== 16'd0) begin
         miscompares++;
         $display("FAIL areset_after: got valid=%b (%0d,%0d) expected 1 (500,0)", x_valid, x_abs, x_n);
      end
   endtask

   task automatic test_random();
      logic        r_en, r_clr, r_rdy;
      logic [31:0] ny;
      int          sel;
      ent_t        h;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         r_en  = ($urandom_range(0, 3) != 0);
         r_clr = ($urandom_range(0, 24) == 0);
         r_rdy = ($urandom_range(0, 2) != 0);
         sel   = $urandom_range(0, 15);
         if (sel == 0)      ny = $urandom;
         else if (sel == 1) ny = m_prev + 32'($urandom_range(2048, 2049));
         else               ny = m_prev + 32'($urandom_range(0, 2048));
         cycle(r_en, ny, r_clr, r_rdy);
         h = exp_head();
         vectors++;
         if (x_valid !== (mq.size() != 0)) begin
            miscompares++;
            $display("FAIL rand_valid[%0d]: got %b expected %b", i, x_valid, mq.size() != 0);
         end
         vectors++;
         if (x_abs !== h.a || x_n !== h.n) begin
            miscompares++;
            $display("FAIL rand_head[%0d]: got (%0d,%0d) expected (%0d,%0d)", i, x_abs, x_n, h.a, h.n);
         end
         vectors++;
         if (err_range !== m_range || err_ovf !== m_ovf) begin
            miscompares++;
            $display("FAIL rand_flags[%0d]: got range=%b ovf=%b expected %b %b", i, err_range, err_ovf, m_range, m_ovf);
         end
      end
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; y = '0; clr = 1'b0; x_ready = 1'b0;
      model_reset();
      #2;
      test_reset();
      test_basic();
      test_wrap();
      test_range();
      test_backpressure();
      test_full_pop();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
